// File: rtl/adder_acc_pkg.sv
// Shared types for the pipelined adder/accumulator: mode encoding, stage-1 payload, result width.
// Stage-1 p field is sized for the widest supported result (W+G <= P_MAX_W); upper bits stay zero.
package adder_acc_pkg;

  localparam int P_MAX_W = 64;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  typedef struct packed {
    logic [P_MAX_W-1:0] p;
    mode_e              mode;
    logic               clr;
  } s1_t;

  function automatic int acc_width(input int w, input int g);
    return w + g;
  endfunction

endpackage

// File: rtl/adder_acc_pipe_if.sv
// Operand/result handshake bundle for adder_acc_pipe; master = producer/consumer side, slave = block.
interface adder_acc_pipe_if
  import adder_acc_pkg::*;
#(
  parameter int W = 8,
  parameter int G = 4
);

  logic           in_valid;
  logic           in_ready;
  mode_e          mode;
  logic           clr;
  logic           cin;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [W+G-1:0] sum;
  logic           zero;
  logic           ovf;
  logic           ovf_sticky;

  modport master (
    output in_valid, mode, clr, cin, x, y, out_ready,
    input  in_ready, out_valid, sum, zero, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, mode, clr, cin, x, y, out_ready,
    output in_ready, out_valid, sum, zero, ovf, ovf_sticky
  );

endinterface

// File: rtl/adder_acc_sat.sv
// Combinational R-bit accumulate step: sum = acc + p, ovf on carry out of bit R-1.
// ADDER_ACC_SAT_EN defined: an overflowing step saturates at 2^R-1 instead of wrapping.
module adder_acc_sat #(
  parameter int R = 12
) (
  input  logic [R-1:0] acc,
  input  logic [R-1:0] p,
  output logic [R-1:0] sum,
  output logic         ovf
);

  logic [R:0] full;

  assign full = {1'b0, acc} + {1'b0, p};
  assign ovf  = full[R];

`ifdef ADDER_ACC_SAT_EN
  assign sum = full[R] ? {R{1'b1}} : full[R-1:0];
`else
  assign sum = full[R-1:0];
`endif

endmodule

// File: rtl/adder_acc_pipe.sv
// Two-stage pipelined adder/accumulator with valid/ready on both sides; latency 2, 1 beat/cycle.
// in_ready drops only when both stages are full and the consumer stalls; ADDER_ACC_SAT_EN selects saturation.
module adder_acc_pipe
  import adder_acc_pkg::*;
#(
  parameter int W = 8,
  parameter int G = 4
) (
  input logic             clk,
  input logic             rst_n,
  adder_acc_pipe_if.slave bus
);

  localparam int R = acc_width(W, G);

  logic         s1_valid;
  s1_t          s1_d, s1_q;
  logic [W:0]   p_in;
  logic         s2_free, s1_adv, in_ready, accept;

  logic         out_valid_q, zero_q, ovf_q, sticky_q;
  logic [R-1:0] sum_q, acc_q;
  logic [R-1:0] p_s1, sat_sum, nxt_sum, nxt_acc;
  logic         sat_ovf, nxt_ovf, nxt_sticky;
  logic         unused_p;

  // Handshake: stage 2 can take a new beat if empty or being drained this cycle.
  assign s2_free  = ~out_valid_q | bus.out_ready;
  assign s1_adv   = s1_valid & s2_free;
  assign in_ready = ~s1_valid | s2_free;
  assign accept   = bus.in_valid & in_ready;

  assign p_in = {1'b0, bus.x} + {1'b0, bus.y} + {{W{1'b0}}, bus.cin};

  always_comb begin
    s1_d         = '0;
    s1_d.p[W:0]  = p_in;
    s1_d.mode    = bus.mode;
    s1_d.clr     = bus.clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  assign p_s1     = s1_q.p[R-1:0];
  assign unused_p = ^s1_q.p;

  adder_acc_sat #(.R(R)) u_sat (
    .acc (acc_q),
    .p   (p_s1),
    .sum (sat_sum),
    .ovf (sat_ovf)
  );

  // Add beats pass p through and leave acc/sticky alone; clr restarts the chain from p.
  always_comb begin
    nxt_sum    = p_s1;
    nxt_ovf    = 1'b0;
    nxt_acc    = acc_q;
    nxt_sticky = sticky_q;
    if (s1_q.mode == MODE_ACC) begin
      if (s1_q.clr) begin
        nxt_acc    = p_s1;
        nxt_sticky = 1'b0;
      end else begin
        nxt_sum    = sat_sum;
        nxt_acc    = sat_sum;
        nxt_ovf    = sat_ovf;
        nxt_sticky = sticky_q | sat_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      acc_q       <= '0;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      sum_q       <= nxt_sum;
      zero_q      <= (nxt_sum == '0);
      ovf_q       <= nxt_ovf;
      sticky_q    <= nxt_sticky;
      acc_q       <= nxt_acc;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.sum        = sum_q;
  assign bus.zero       = zero_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_adder_acc_pipe.sv
// Bench for adder_acc_pipe (W=8, G=4): directed scenarios plus random traffic against a queue-based model.
module tb_adder_acc_pipe;
  import adder_acc_pkg::*;

  localparam int W    = 8;
  localparam int G    = 4;
  localparam int R    = W + G;
  localparam int RMAX = (1 << R) - 1;

  typedef struct {
    int sum;
    bit zero;
    bit ovf;
    bit sticky;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t expq[$];
  int   macc;
  bit   msticky;
  int   errors;
  int   checks;

  adder_acc_pipe_if #(.W(W), .G(G)) bus ();

  adder_acc_pipe #(.W(W), .G(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit m, input bit c, input bit ci, input int xx, input int yy);
    bus.in_valid = v;
    bus.mode     = m ? MODE_ACC : MODE_ADD;
    bus.clr      = c;
    bus.cin      = ci;
    bus.x        = 8'(xx);
    bus.y        = 8'(yy);
  endtask

  // Reference: each accepted beat produces exactly one result, in acceptance order.
  task automatic model_accept();
    int   p;
    int   t;
    exp_t e;
    p     = int'(bus.x) + int'(bus.y) + int'(bus.cin);
    e.ovf = 1'b0;
    if (bus.mode == MODE_ADD) begin
      e.sum = p;
    end else if (bus.clr) begin
      macc    = p;
      msticky = 1'b0;
      e.sum   = p;
    end else begin
      t = macc + p;
      if (t > RMAX) begin
        e.ovf = 1'b1;
`ifdef ADDER_ACC_SAT_EN
        t = RMAX;
`else
        t = t - (RMAX + 1);
`endif
      end
      macc    = t;
      msticky = msticky | e.ovf;
      e.sum   = t;
    end
    e.zero   = (e.sum == 0);
    e.sticky = msticky;
    expq.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (expq.size() == 0) begin
      chk("spurious_out", 32'(bus.out_valid), 0);
    end else begin
      e = expq.pop_front();
      chk("out_sum",    32'(bus.sum),        e.sum);
      chk("out_zero",   32'(bus.zero),       32'(e.zero));
      chk("out_ovf",    32'(bus.ovf),        32'(e.ovf));
      chk("out_sticky", 32'(bus.ovf_sticky), 32'(e.sticky));
    end
  endtask

  // Observe both handshakes with the current inputs, then advance to the next falling edge.
  task automatic tick();
    #1;
    if (bus.out_valid && bus.out_ready) check_out();
    if (bus.in_valid && bus.in_ready) model_accept();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((expq.size() != 0 || bus.out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < 50), 1);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    expq.delete();
    macc    = 0;
    msticky = 1'b0;
    #1;
    chk("rst_out_valid",  32'(bus.out_valid),  0);
    chk("rst_sum",        32'(bus.sum),        0);
    chk("rst_zero",       32'(bus.zero),       0);
    chk("rst_ovf",        32'(bus.ovf),        0);
    chk("rst_ovf_sticky", 32'(bus.ovf_sticky), 0);
    chk("rst_in_ready",   32'(bus.in_ready),   1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Add mode and two-cycle latency
    drive(1, 0, 0, 1, 200, 100);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("lat_n1_no_valid", 32'(bus.out_valid), 0);
    tick();
    chk("lat_n2_valid", 32'(bus.out_valid), 1);
    chk("add_301", 32'(bus.sum), 301);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("add_zero_flag", 32'(bus.zero), 1);
    drain();

    // Accumulate chain: results on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, (i == 0), 0, 16, 16);
      tick();
      if (i >= 1) chk("chain_no_bubble", 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("chain_last_valid", 32'(bus.out_valid), 1);
    chk("chain_last_sum", 32'(bus.sum), 128);
    drain();

    // Wrap or saturate, then clr clears sticky
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, (i == 0), 1, 255, 255);
      tick();
    end
    drive(1, 1, 1, 0, 0, 0);
    tick();
    drain();

    // Back-pressure: out_ready low on cycles 3..6
    begin : bp
      int c;
      int sent;
      c    = 0;
      sent = 0;
      while ((sent < 6 || expq.size() != 0) && c < 40) begin
        c++;
        bus.out_ready = !(c >= 3 && c <= 6);
        if (sent < 6) drive(1, 0, 0, $urandom % 2, $urandom % 256, $urandom % 256);
        else bus.in_valid = 1'b0;
        #1;
        if (c >= 3 && c <= 6) begin
          chk("bp_in_ready_low", 32'(bus.in_ready), 0);
          chk("bp_out_held_valid", 32'(bus.out_valid), 1);
          if (expq.size() != 0) chk("bp_hold_sum", 32'(bus.sum), expq[0].sum);
        end
        if (bus.in_valid && bus.in_ready) sent++;
        tick();
      end
      chk("bp_all_sent", sent, 6);
    end
    drain();

    // Interleaved modes: add beat does not disturb accumulator
    drive(1, 1, 1, 0, 5, 5);
    tick();
    drive(1, 0, 0, 0, 1, 1);
    tick();
    drive(1, 1, 0, 0, 3, 4);
    tick();
    drain();

    // Reset with two beats in flight, sticky set on the beat held in stage 2
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, (i == 0), 1, 255, 255);
      tick();
    end
    do_reset();
    drive(1, 1, 0, 0, 3, 4);
    tick();
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom % 3) != 0;
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0, $urandom % 2,
            $urandom % 256, $urandom % 256);
      tick();
    end
    drain();
    chk("final_queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
